// File: rtl/lms_pkg.sv
// lms_pkg: shared definitions for the LMS receive stream path.
//   CH_A / CH_B : values of the iqsel_rx lane marker (I word / Q word).
//   rx_state_t  : receive pairing FSM state type.
package lms_pkg;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    GET_Q  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/lms_rx_fifo.sv
// lms_rx_fifo: first-word-fall-through FIFO for completed I/Q pairs.
//   mclk_rx, rstn_rx : clock, synchronous active-low reset
//   wr_en, wr_data   : write request; a write into a full FIFO is accepted
//                      only when a pop happens in the same cycle
//   rd_en            : pop request, ignored while empty
//   rd_data          : head word; while empty it holds the last popped word
//   full, empty      : occupancy flags derived from the registered pointers
module lms_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             mclk_rx,
  input  logic             rstn_rx,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] last_reg;
  logic             do_rd;
  logic             do_wr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign do_rd = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_wr = wr_en && (!full || do_rd);

  // Head word falls through; when empty, show the most recently popped word.
  assign rd_data = empty ? last_reg : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge mclk_rx) begin
    if (do_wr) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge mclk_rx) begin
    if (!rstn_rx) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      last_reg   <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        last_reg   <= mem[rd_ptr_reg[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/lms_rx_stream.sv
// lms_rx_stream: pairs interleaved LMS receive words into {I,Q}, decimates
// the pair stream and buffers it in an FWFT FIFO.
//   mclk_rx, rstn_rx : clock, synchronous active-low reset
//   dio_rx, iqsel_rx : sample bus and lane marker (CH_A first, CH_B second)
//   enable           : capture enable; low returns to IDLE, FIFO is kept
//   iq_swap          : CH_A word is Q and CH_B word is I when set
//   decim            : keep one of every decim+1 completed pairs
//   out_data/valid/ready : FWFT stream of {I,Q}, components sign-extended
//   ovf_cnt          : saturating count of pairs dropped on a full FIFO
//   sync_err         : one-cycle pulse when two CH_A words arrive in a row
//   rxen_rx, txnrx_rx, fclk_rx : fixed LMS control levels
module lms_rx_stream
  import lms_pkg::*;
#(
  parameter int DW    = 12,
  parameter int OW    = 16,
  parameter int DEPTH = 8,
  parameter int DECW  = 4
) (
  input  logic            mclk_rx,
  input  logic            rstn_rx,
  input  logic [DW-1:0]   dio_rx,
  input  logic            iqsel_rx,
  input  logic            enable,
  input  logic            iq_swap,
  input  logic [DECW-1:0] decim,
  output logic [2*OW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     ovf_cnt,
  output logic            sync_err,
  output logic            rxen_rx,
  output logic            txnrx_rx,
  output logic            fclk_rx
);

  rx_state_t       state_reg;
  logic [DW-1:0]   held_reg;
  logic [DECW-1:0] dec_cnt_reg;
  logic [DECW-1:0] dec_lim_reg;
  logic            sync_err_reg;
  logic [15:0]     ovf_cnt_reg;

  logic            pair_done;
  logic            keep;
  logic            pop;
  logic            drop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [DW-1:0]   i_word;
  logic [DW-1:0]   q_word;
  logic [2*OW-1:0] pair_data;

  assign pair_done = rstn_rx && enable && (state_reg == GET_Q) && (iqsel_rx == CH_B);
  assign keep      = pair_done && (dec_cnt_reg == '0);

  // Held word arrived on CH_A; the word completing the pair is on CH_B.
  assign i_word    = iq_swap ? dio_rx   : held_reg;
  assign q_word    = iq_swap ? held_reg : dio_rx;
  assign pair_data = {OW'($signed(i_word)), OW'($signed(q_word))};

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = keep && fifo_full && !pop;

  lms_rx_fifo #(
    .WIDTH (2*OW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .mclk_rx (mclk_rx),
    .rstn_rx (rstn_rx),
    .wr_en   (keep),
    .wr_data (pair_data),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge mclk_rx) begin
    if (!rstn_rx) begin
      state_reg    <= IDLE;
      held_reg     <= '0;
      dec_cnt_reg  <= '0;
      dec_lim_reg  <= '0;
      sync_err_reg <= 1'b0;
      ovf_cnt_reg  <= '0;
    end else begin
      sync_err_reg <= 1'b0;
      if (!enable) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg   <= WAIT_I;
            dec_cnt_reg <= '0;
            dec_lim_reg <= decim;
          end
          WAIT_I: begin
            if (iqsel_rx == CH_A) begin
              held_reg  <= dio_rx;
              state_reg <= GET_Q;
            end
          end
          GET_Q: begin
            if (iqsel_rx == CH_B) begin
              state_reg <= WAIT_I;
              // New decim is picked up only when the count wraps.
              if (dec_cnt_reg == dec_lim_reg) begin
                dec_cnt_reg <= '0;
                dec_lim_reg <= decim;
              end else begin
                dec_cnt_reg <= dec_cnt_reg + DECW'(1);
              end
            end else begin
              sync_err_reg <= 1'b1;
              held_reg     <= dio_rx;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
      if (drop && (ovf_cnt_reg != 16'hFFFF)) begin
        ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
      end
    end
  end

  assign ovf_cnt  = ovf_cnt_reg;
  assign sync_err = sync_err_reg;
  assign rxen_rx  = 1'b1;
  assign txnrx_rx = 1'b0;
  assign fclk_rx  = 1'b0;

endmodule

// File: tb/tb_lms_rx_stream.sv
module tb_lms_rx_stream;

  localparam int DEPTH = 8;

  logic        mclk_rx = 1'b0;
  logic        rstn_rx = 1'b0;
  logic [11:0] dio_rx = '0;
  logic        iqsel_rx = 1'b0;
  logic        enable = 1'b0;
  logic        iq_swap = 1'b0;
  logic [3:0]  decim = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] ovf_cnt;
  logic        sync_err;
  logic        rxen_rx;
  logic        txnrx_rx;
  logic        fclk_rx;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  lms_rx_stream #(.DW(12), .OW(16), .DEPTH(DEPTH), .DECW(4)) dut (
    .mclk_rx  (mclk_rx),
    .rstn_rx  (rstn_rx),
    .dio_rx   (dio_rx),
    .iqsel_rx (iqsel_rx),
    .enable   (enable),
    .iq_swap  (iq_swap),
    .decim    (decim),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf_cnt  (ovf_cnt),
    .sync_err (sync_err),
    .rxen_rx  (rxen_rx),
    .txnrx_rx (txnrx_rx),
    .fclk_rx  (fclk_rx)
  );

  always #5 mclk_rx = ~mclk_rx;

  // ---------------- behavioural reference ----------------
  // Receiver activity: 0 = off, 1 = looking for an I word, 2 = holding a first word.
  int          m_phase = 0;
  logic [11:0] m_first = '0;
  int          m_pair_no = 0;   // completed pairs since last wrap
  int          m_period = 1;    // decim+1 in force
  logic [31:0] m_q [$];
  logic [31:0] m_last = '0;
  int          m_ovf = 0;
  bit          m_serr = 1'b0;

  function automatic logic [15:0] sx(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  always @(posedge mclk_rx) begin
    bit had_items;
    bit was_full;
    bit keep;
    logic [31:0] pair;
    had_items = (m_q.size() > 0);
    was_full  = (m_q.size() == DEPTH);
    keep = 1'b0;
    pair = '0;
    if (!rstn_rx) begin
      m_phase = 0; m_pair_no = 0; m_period = 1;
      m_q.delete(); m_last = '0; m_ovf = 0; m_serr = 1'b0;
    end else begin
      m_serr = 1'b0;
      if (!enable) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        m_phase = 1; m_pair_no = 0; m_period = int'(decim) + 1;
      end else if (m_phase == 1) begin
        if (!iqsel_rx) begin m_first = dio_rx; m_phase = 2; end
      end else begin
        if (iqsel_rx) begin
          keep = (m_pair_no == 0);
          pair = iq_swap ? {sx(dio_rx), sx(m_first)} : {sx(m_first), sx(dio_rx)};
          m_pair_no = m_pair_no + 1;
          if (m_pair_no == m_period) begin
            m_pair_no = 0; m_period = int'(decim) + 1;
          end
          m_phase = 1;
        end else begin
          m_serr = 1'b1; m_first = dio_rx;
        end
      end
      if (had_items && out_ready) m_last = m_q.pop_front();
      if (keep) begin
        if (was_full && !(had_items && out_ready)) begin
          if (m_ovf < 65535) m_ovf = m_ovf + 1;
        end else begin
          m_q.push_back(pair);
        end
      end
    end
  end

  // Single per-cycle compare of all outputs against the reference.
  always @(negedge mclk_rx) begin
    logic [31:0] exp_data;
    if (chk_en) begin
      exp_data = (m_q.size() > 0) ? m_q[0] : m_last;
      total = total + 4;
      if (out_valid !== (m_q.size() > 0)) begin
        bad = bad + 1;
        $display("FAIL model_valid t=%0t got=%b exp=%b", $time, out_valid, (m_q.size() > 0));
      end
      if (out_data !== exp_data) begin
        bad = bad + 1;
        $display("FAIL model_data t=%0t got=%h exp=%h", $time, out_data, exp_data);
      end
      if (ovf_cnt !== 16'(m_ovf)) begin
        bad = bad + 1;
        $display("FAIL model_ovf t=%0t got=%0d exp=%0d", $time, ovf_cnt, m_ovf);
      end
      if (sync_err !== m_serr) begin
        bad = bad + 1;
        $display("FAIL model_serr t=%0t got=%b exp=%b", $time, sync_err, m_serr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic cyc(input logic rn, input logic en, input logic sel,
                     input logic [11:0] d, input logic rdy, input logic swp);
    rstn_rx = rn; enable = en; iqsel_rx = sel; dio_rx = d; out_ready = rdy; iq_swap = swp;
    @(posedge mclk_rx);
    @(negedge mclk_rx);
    #1;
  endtask

  initial begin
    logic [15:0] seen [$];
    logic        sel_prev;
    // Reset state
    cyc(0, 0, 0, 12'h0, 0, 0);
    chk_en = 1'b1;
    cyc(0, 0, 0, 12'h0, 0, 0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_data", out_data, 32'h0);
    chk("reset_ovf", 32'(ovf_cnt), 32'h0);
    chk("const_pins", {29'h0, rxen_rx, txnrx_rx, fclk_rx}, 32'h4);

    // Basic pair, then swapped pair
    cyc(1, 1, 1, 12'h000, 1, 0);
    cyc(1, 1, 0, 12'h7FF, 1, 0);
    chk("first_word_no_valid", 32'(out_valid), 32'h0);
    cyc(1, 1, 1, 12'h800, 1, 0);
    chk("pair_valid", 32'(out_valid), 32'h1);
    chk("pair_data", out_data, 32'h07FF_F800);
    cyc(1, 1, 0, 12'h7FF, 1, 1);
    chk("popped_empty", 32'(out_valid), 32'h0);
    chk("hold_last", out_data, 32'h07FF_F800);
    cyc(1, 1, 1, 12'h800, 1, 1);
    chk("swap_data", out_data, 32'hF800_07FF);
    cyc(1, 1, 1, 12'h000, 1, 0);

    // Sequence violation: 0,0,1
    cyc(1, 1, 0, 12'h123, 1, 0);
    cyc(1, 1, 0, 12'h456, 1, 0);
    chk("sync_err_pulse", 32'(sync_err), 32'h1);
    cyc(1, 1, 1, 12'h789, 1, 0);
    chk("sync_err_clear", 32'(sync_err), 32'h0);
    chk("resync_pair", out_data, 32'h0456_0789);
    cyc(1, 1, 1, 12'h000, 1, 0);

    // Decimation 1 of 4
    decim = 4'd3;
    cyc(1, 0, 1, 12'h000, 1, 0);
    cyc(1, 1, 1, 12'h000, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 1, 0, 12'(k), 1, 0);
      if (out_valid) seen.push_back(out_data[31:16]);
      cyc(1, 1, 1, 12'(16 + k), 1, 0);
      if (out_valid) seen.push_back(out_data[31:16]);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, 1, 12'h000, 1, 0);
      if (out_valid) seen.push_back(out_data[31:16]);
    end
    chk("decim_count", 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      chk("decim_first", 32'(seen[0]), 32'd1);
      chk("decim_second", 32'(seen[1]), 32'd5);
    end
    decim = 4'd0;
    cyc(1, 0, 1, 12'h000, 1, 0);
    cyc(1, 1, 1, 12'h000, 0, 0);

    // Overflow: 10 pairs into 8 slots
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 1, 0, 12'(k), 0, 0);
      cyc(1, 1, 1, 12'h0AA, 0, 0);
    end
    chk("ovf_two", 32'(ovf_cnt), 32'd2);
    chk("ovf_head", 32'(out_data[31:16]), 32'd1);
    cyc(1, 1, 0, 12'h0BB, 0, 0);
    cyc(1, 1, 1, 12'h0CC, 1, 0);
    chk("ovf_pop_write", 32'(ovf_cnt), 32'd2);
    chk("ovf_new_head", 32'(out_data[31:16]), 32'd2);

    // Reset while in GET_Q with 3 pairs stored
    for (int k = 0; k < 5; k++) cyc(1, 1, 1, 12'h000, 1, 0);
    cyc(1, 1, 0, 12'h321, 0, 0);
    chk("pre_reset_valid", 32'(out_valid), 32'h1);
    cyc(0, 1, 1, 12'h654, 0, 0);
    chk("mid_reset_valid", 32'(out_valid), 32'h0);
    chk("mid_reset_ovf", 32'(ovf_cnt), 32'h0);
    chk("mid_reset_serr", 32'(sync_err), 32'h0);
    cyc(1, 1, 1, 12'h555, 0, 0);
    chk("post_reset_idle", 32'(out_valid), 32'h0);

    // Randomized traffic against the reference
    sel_prev = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      logic s;
      s = (($urandom % 10) == 0) ? sel_prev : ~sel_prev;
      sel_prev = s;
      if (($urandom % 60) == 0) decim = 4'($urandom_range(0, 3));
      cyc((($urandom % 300) != 0), (($urandom % 50) != 0), s, 12'($urandom),
          ((n / 200) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 4) == 0),
          1'($urandom));
    end
    for (int n = 0; n < 12; n++) cyc(1, 0, 1, 12'h000, 1, 0);
    chk("final_drained", 32'(out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lms_rx_stream.md
LMS_RX_STREAM -- requirements
Module: lms_rx_stream

Interface
REQ-001 Parameter DW, default 12: LMS data bus width in bits.
REQ-002 Parameter OW, default 16: output I/Q component width in bits; SHALL be at least DW.
REQ-003 Parameter DEPTH, default 8: output FIFO depth in pairs; SHALL be a power of 2 and at least 2.
REQ-004 Parameter DECW, default 4: width of the decimation control.
REQ-005 mclk_rx  in  1: the single clock; all logic on the rising edge.
REQ-006 rstn_rx  in  1: reset, synchronous, active-low.
REQ-007 dio_rx  in  DW: interleaved I/Q sample bus, two's complement.
REQ-008 iqsel_rx  in  1: lane marker; 0 (CH_A) = I word, 1 (CH_B) = Q word.
REQ-009 enable  in  1: capture enable.
REQ-010 iq_swap  in  1: 1 = treat the CH_A word as Q and the CH_B word as I.
REQ-011 decim  in  DECW: keep 1 of every decim+1 completed pairs.
REQ-012 out_data  out  2*OW: {I,Q}, each component sign-extended from DW to OW.
REQ-013 out_valid  out  1: FIFO not empty.
REQ-014 out_ready  in  1: consumer accept; a pop occurs when out_valid and out_ready are both 1.
REQ-015 ovf_cnt  out  16: count of dropped pairs; saturates at 16'hFFFF.
REQ-016 sync_err  out  1: one-cycle pulse on an I/Q sequence violation.
REQ-017 rxen_rx, txnrx_rx, fclk_rx  out  1 each: constants 1, 0, 0.

Function
REQ-018 The FSM SHALL have three states: IDLE, WAIT_I and GET_Q.
REQ-019 IDLE -> WAIT_I when enable=1; any state -> IDLE when enable=0, discarding any held partial pair.
REQ-020 In WAIT_I with iqsel_rx=0: latch dio_rx as the first word and go to GET_Q; with iqsel_rx=1: ignore the word and stay in WAIT_I (no error).
REQ-021 In GET_Q with iqsel_rx=1: complete the pair and go to WAIT_I.
REQ-022 In GET_Q with iqsel_rx=0: pulse sync_err, replace the held word with the new one and stay in GET_Q.
REQ-023 Latency: first word sampled at edge n, second at edge n+1; the kept pair is written to the FIFO at edge n+1 and out_valid is visible after edge n+1 when the FIFO was empty.
REQ-024 Decimation: a modulo counter runs from 0 to decim; a pair is kept only when the counter is 0.
REQ-025 The decimation counter SHALL advance on every completed pair, wrap at decim, and clear when leaving IDLE.
REQ-026 A change of decim takes effect at the next wrap.
REQ-027 The FIFO SHALL be first-word-fall-through: out_data is valid whenever out_valid=1.
REQ-028 Full FIFO with a pair to write and no pop in the same cycle: drop the pair and increment ovf_cnt (saturating).
REQ-029 Full FIFO with a pair to write and a simultaneous pop: accept the write; no drop occurs.
REQ-030 Empty FIFO: a pop request SHALL be ignored and out_data holds its last value.
REQ-031 Deasserting enable SHALL NOT flush the FIFO; stored pairs remain drainable.
REQ-032 iq_swap is sampled when each pair completes and applies to that whole pair.

Reset
REQ-033 On rstn_rx=0 at a clock edge: FSM to IDLE; FIFO pointers to 0; decimation counter to 0; ovf_cnt to 0; sync_err to 0; out_valid to 0; out_data to 0.
REQ-034 Reset asserted mid-pair or mid-burst SHALL discard all data with no sync_err pulse.

Structure
REQ-035 Package lms_pkg SHALL hold the CH_A/CH_B constants and the FSM state type.
REQ-036 A single sub-module, lms_rx_fifo (parameters WIDTH and DEPTH; FWFT; full/empty outputs), SHALL hold the storage.

Verification
REQ-037 enable=1, decim=0, out_ready=1, words (iqsel 0,1) 12'h7FF,12'h800 -> out_data=32'h07FF_F800, out_valid after edge n+1.
REQ-038 iq_swap=1 with the same words -> out_data=32'hF800_07FF.
REQ-039 decim=3, 8 pairs with I=1..8 -> exactly 2 outputs with I=1 and I=5.
REQ-040 out_ready=0, DEPTH=8, 10 pairs -> 8 stored, ovf_cnt=2; then one pop plus one new pair in the same cycle -> ovf_cnt stays 2.
REQ-041 iqsel sequence 0,0,1 -> one sync_err pulse, one pair formed from the 2nd and 3rd words.
REQ-042 rstn_rx=0 while in GET_Q with 3 pairs stored -> next cycle out_valid=0, ovf_cnt=0, FSM in IDLE.
